// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/DMA arbiter in front of the single-port DataMemory
//
// Shares one DataMemory port between the CPU MEM stage (priority) and a DMA
// port. A starvation counter forces a bounded DMA burst while the CPU stalls.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   cpu_re/we/addr/wdata, cpu_rdata, cpu_stall     CPU MEM-stage side
//   dma_req/we/addr/wdata, dma_gnt, dma_rdata, dma_rvalid   DMA side
//   mem_addr/wdata/re/we, mem_rdata                DataMemory side
module dmem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8,
    parameter int MAX_BURST    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_LIMIT - 1);
    localparam logic [BW-1:0] BURST_LAST  = BW'(MAX_BURST - 1);

    typedef enum logic {NORM, FORCE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
    logic [BW-1:0]     burst_cnt_q, burst_cnt_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
    logic              dma_rvalid_q, dma_rvalid_d;
    owner_t            owner;
    logic              cpu_req;

    assign cpu_req = cpu_re | cpu_we;

    // Arbitration decision. Holding owner at NONE during reset gates every
    // combinational output, so no grant can be issued and lost while reset.
    always_comb begin
        owner = OWN_NONE;
        if (!reset) begin
            if (state_q == FORCE) begin
                if (dma_req)      owner = OWN_DMA;
                else if (cpu_req) owner = OWN_CPU;
            end else begin
                if (cpu_req)      owner = OWN_CPU;
                else if (dma_req) owner = OWN_DMA;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= NORM;
            starve_cnt_q <= '0;
            burst_cnt_q  <= '0;
            dma_rdata_q  <= '0;
            dma_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
            dma_rdata_q  <= dma_rdata_d;
            dma_rvalid_q <= dma_rvalid_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        burst_cnt_d  = burst_cnt_q;
        dma_rdata_d  = dma_rdata_q;
        dma_rvalid_d = 1'b0;
        if (state_q == NORM) begin
            if (cpu_req && dma_req) begin
                // Compare the pre-increment value so the LIMIT-th denied
                // cycle is the one that switches to FORCE.
                if (starve_cnt_q == STARVE_LAST) begin
                    state_d      = FORCE;
                    starve_cnt_d = '0;
                    burst_cnt_d  = '0;
                end else begin
                    starve_cnt_d = starve_cnt_q + SW'(1);
                end
            end else begin
                starve_cnt_d = '0;
            end
        end else begin
            if (dma_req) begin
                if (burst_cnt_q == BURST_LAST) begin
                    state_d     = NORM;
                    burst_cnt_d = '0;
                end else begin
                    burst_cnt_d = burst_cnt_q + BW'(1);
                end
            end else begin
                // DMA finished early: hand the port back in this same cycle.
                state_d     = NORM;
                burst_cnt_d = '0;
            end
        end
        if (owner == OWN_DMA && !dma_we) begin
            dma_rdata_d  = mem_rdata;
            dma_rvalid_d = 1'b1;
        end
    end

    // Output logic
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        case (owner)
            OWN_CPU: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_re    = cpu_re;
                mem_we    = cpu_we;
            end
            OWN_DMA: begin
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
                mem_re    = ~dma_we;
                mem_we    = dma_we;
            end
            default: ;
        endcase
        dma_gnt   = (owner == OWN_DMA);
        cpu_stall = cpu_req && !reset && (owner != OWN_CPU);
    end

    assign cpu_rdata  = mem_rdata;
    assign dma_rdata  = dma_rdata_q;
    assign dma_rvalid = dma_rvalid_q;

endmodule
